// File: rtl/ff_bank_arbiter.sv
// Arbitrates N requesters onto one shared W-bit register: clears win by lowest index,
// writes rotate round-robin, and every access is followed by GAP cooldown cycles.
module ff_bank_arbiter #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int GAP = 2
) (
    input  logic           CK,
    input  logic           SR_N,
    input  logic [N-1:0]   REQ,
    input  logic [N-1:0]   CLR,
    input  logic [N*W-1:0] DIN,
    output logic [N-1:0]   GNT,
    output logic           CE_O,
    output logic           SR_O,
    output logic [W-1:0]   Q,
    output logic           BUSY
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR, COOL} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win, win_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic [PW-1:0] clr_idx, rr_idx;
    logic          clr_hit, rr_hit;

    // Descending scans so the last assignment is the highest-priority candidate.
    always_comb begin
        clr_hit = 1'b0;
        clr_idx = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (CLR[i]) begin
                clr_hit = 1'b1;
                clr_idx = PW'(i);
            end
        end
    end

    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (REQ[(int'(ptr) + i) % N]) begin
                rr_hit = 1'b1;
                rr_idx = PW'((int'(ptr) + i) % N);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        win_nxt   = win;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clr_hit) begin
                    state_nxt = CLEAR;
                    win_nxt   = clr_idx;
                end else if (rr_hit) begin
                    state_nxt = WRITE;
                    win_nxt   = rr_idx;
                end
            end
            WRITE, CLEAR: begin
                if (GAP == 0) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = COOL;
                    cnt_nxt   = 4'(GAP - 1);
                end
            end
            COOL: begin
                if (cnt == 4'd0) state_nxt = IDLE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (!SR_N) begin
            state <= IDLE;
            win   <= '0;
            ptr   <= '0;
            cnt   <= '0;
            Q     <= '0;
        end else begin
            state <= state_nxt;
            win   <= win_nxt;
            cnt   <= cnt_nxt;
            if (state == WRITE) begin
                Q   <= DIN[win*W +: W];
                ptr <= (win == PW'(N-1)) ? '0 : win + PW'(1);
            end else if (state == CLEAR) begin
                Q <= '0;
            end
        end
    end

    // Strobes decode straight from registered state, so they move only on CK edges.
    always_comb begin
        GNT  = ((state == WRITE) || (state == CLEAR)) ? (N'(1) << win) : '0;
        CE_O = (state == WRITE);
        SR_O = (state == CLEAR);
        BUSY = (state != IDLE);
    end

endmodule

// File: tb/tb_ff_bank_arbiter.sv
// Directed bench for ff_bank_arbiter: expected grants go into a scoreboard queue,
// a negedge monitor pops and compares them; a second GAP=0 instance checks back-to-back grants.
module tb_ff_bank_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           CK = 1'b0;
    logic           SR_N;
    logic [N-1:0]   REQ, CLR;
    logic [N*W-1:0] DIN;
    logic [N-1:0]   GNT;
    logic           CE_O, SR_O, BUSY;
    logic [W-1:0]   Q;

    logic           sr_n0;
    logic [N-1:0]   req0, clr0;
    logic [N*W-1:0] din0;
    logic [N-1:0]   gnt0;
    logic           ce0, so0, busy0;
    logic [W-1:0]   q0;

    ff_bank_arbiter #(.N(N), .W(W), .GAP(2)) dut (
        .CK(CK), .SR_N(SR_N), .REQ(REQ), .CLR(CLR), .DIN(DIN),
        .GNT(GNT), .CE_O(CE_O), .SR_O(SR_O), .Q(Q), .BUSY(BUSY)
    );

    ff_bank_arbiter #(.N(N), .W(W), .GAP(0)) dut_g0 (
        .CK(CK), .SR_N(sr_n0), .REQ(req0), .CLR(clr0), .DIN(din0),
        .GNT(gnt0), .CE_O(ce0), .SR_O(so0), .Q(q0), .BUSY(busy0)
    );

    always #5 CK = ~CK;

    typedef struct {
        logic [N-1:0] gnt;
        logic         ce;
        logic         sr;
        logic [W-1:0] q;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    bit           started = 0;
    bit           q_pend = 0;
    logic [W-1:0] q_exp;

    always @(posedge CK) cyc <= cyc + 1;

    // Monitor: a grant pops one expectation; Q is checked on the following cycle.
    always @(negedge CK) begin
        if (started) begin
            if (q_pend) begin
                checks++;
                if (Q !== q_exp) begin
                    errors++;
                    $display("FAIL q_after_grant cyc=%0d: got %h want %h", cyc, Q, q_exp);
                end
                q_pend = 0;
            end
            checks++;
            if (!$onehot0(GNT) || (CE_O && SR_O)) begin
                errors++;
                $display("FAIL exclusive cyc=%0d: got gnt=%b ce=%b sr=%b want onehot0 and not both strobes",
                         cyc, GNT, CE_O, SR_O);
            end
            if (GNT !== '0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_grant cyc=%0d: got gnt=%b want none", cyc, GNT);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (GNT !== e.gnt || CE_O !== e.ce || SR_O !== e.sr || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL grant: got gnt=%b ce=%b sr=%b cyc=%0d want gnt=%b ce=%b sr=%b cyc=%0d",
                                 GNT, CE_O, SR_O, cyc, e.gnt, e.ce, e.sr, e.cyc);
                    end
                    q_pend = 1;
                    q_exp  = e.q;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CK);
        #1;
    endtask

    task automatic push(input logic [N-1:0] g, input logic ce, input logic sr,
                        input logic [W-1:0] q, input int c);
        exp_t e;
        e.gnt = g; e.ce = ce; e.sr = sr; e.q = q; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic set_din(input int k, input logic [W-1:0] v);
        DIN[k*W +: W] = v;
    endtask

    initial begin
        int c;
        int busy_cnt;
        int ce_cnt;
        logic [N-1:0] g_exp;
        logic [W-1:0] qx;

        SR_N = 1'b0; REQ = '0; CLR = '0; DIN = '0;
        sr_n0 = 1'b0; req0 = '0; clr0 = '0; din0 = '0;
        tick(2);
        SR_N = 1'b1; sr_n0 = 1'b1;
        chk("reset_gnt", 32'(GNT), 32'h0);
        chk("reset_strobes", {30'h0, CE_O, SR_O}, 32'h0);
        chk("reset_q", 32'(Q), 32'h0);
        chk("reset_busy", 32'(BUSY), 32'h0);
        started = 1;

        // single write, BUSY length 1+GAP
        c = cyc;
        set_din(0, 8'hA5); REQ = 4'b0001;
        push(4'b0001, 1'b1, 1'b0, 8'hA5, c + 1);
        tick(1);
        REQ = '0;
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (BUSY) busy_cnt++;
            tick(1);
        end
        chk("busy_cycles", 32'(busy_cnt), 32'd3);

        // reset back to P=0 before rotation
        SR_N = 1'b0;
        tick(1);
        SR_N = 1'b1;
        chk("rereset_q", 32'(Q), 32'h0);

        // round robin, all requests held
        c = cyc;
        for (int k = 0; k < N; k++) set_din(k, 8'(8'h10 + k));
        REQ = 4'b1111;
        push(4'b0001, 1'b1, 1'b0, 8'h10, c + 1);
        push(4'b0010, 1'b1, 1'b0, 8'h11, c + 5);
        push(4'b0100, 1'b1, 1'b0, 8'h12, c + 9);
        push(4'b1000, 1'b1, 1'b0, 8'h13, c + 13);
        push(4'b0001, 1'b1, 1'b0, 8'h10, c + 17);
        tick(17);
        REQ = '0;
        tick(4);

        // load A5 through requester 1 (P=1)
        c = cyc;
        set_din(1, 8'hA5); REQ = 4'b0010;
        push(4'b0010, 1'b1, 1'b0, 8'hA5, c + 1);
        tick(1);
        REQ = '0;
        tick(3);

        // clear priority over a simultaneous write
        c = cyc;
        set_din(2, 8'h77); REQ = 4'b0100; CLR = 4'b0010;
        push(4'b0010, 1'b0, 1'b1, 8'h00, c + 1);
        push(4'b0100, 1'b1, 1'b0, 8'h77, c + 5);
        tick(1);
        CLR = '0;
        tick(4);
        REQ = '0;
        tick(3);

        // P=3 must survive a clear by requester 1: next write goes to 0, not 2
        c = cyc;
        set_din(0, 8'h5A); REQ = 4'b0101; CLR = 4'b0010;
        push(4'b0010, 1'b0, 1'b1, 8'h00, c + 1);
        push(4'b0001, 1'b1, 1'b0, 8'h5A, c + 5);
        tick(1);
        CLR = '0;
        tick(4);
        REQ = '0;
        tick(3);

        // reset during the WRITE cycle (P=1)
        c = cyc;
        set_din(1, 8'h3C); REQ = 4'b0010;
        push(4'b0010, 1'b1, 1'b0, 8'h00, c + 1);
        tick(1);
        SR_N = 1'b0; REQ = '0;
        tick(1);
        SR_N = 1'b1;
        chk("midreset_q", 32'(Q), 32'h0);
        chk("midreset_busy", 32'(BUSY), 32'h0);
        chk("midreset_gnt", 32'(GNT), 32'h0);
        tick(6);
        chk("midreset_no_late_write", 32'(Q), 32'h0);

        // late request raised during COOL
        c = cyc;
        set_din(0, 8'h42); REQ = 4'b0001;
        push(4'b0001, 1'b1, 1'b0, 8'h42, c + 1);
        tick(1);
        REQ = '0;
        tick(1);
        set_din(3, 8'h99); REQ = 4'b1000;
        push(4'b1000, 1'b1, 1'b0, 8'h99, c + 5);
        tick(3);
        REQ = '0;
        tick(4);

        // GAP=0 instance: alternating grants, 50% CE_O
        din0[0*W +: W] = 8'h21; din0[1*W +: W] = 8'h22;
        req0 = 4'b0011;
        tick(1);
        ce_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            g_exp = (i % 2 == 1) ? 4'b0000 : ((i % 4 == 0) ? 4'b0001 : 4'b0010);
            qx    = (i == 0) ? 8'h00 : ((((i - 1) / 2) % 2 == 0) ? 8'h21 : 8'h22);
            chk($sformatf("gap0_gnt_%0d", i), 32'(gnt0), 32'(g_exp));
            chk($sformatf("gap0_q_%0d", i), 32'(q0), 32'(qx));
            if (ce0) ce_cnt++;
            tick(1);
        end
        req0 = '0;
        chk("gap0_ce_duty", 32'(ce_cnt), 32'd4);

        tick(2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_grants: got %0d pending want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ff_bank_arbiter.md
FF_BANK_ARBITER -- requirements
Module: ff_bank_arbiter

Interface
REQ-001 The module SHALL take parameter N, default 4, meaning the number of requesters (2..8).
REQ-002 The module SHALL take parameter W, default 8, meaning the width of the shared register.
REQ-003 The module SHALL take parameter GAP, default 2, meaning the number of cooldown cycles after each access (0..15).
REQ-004 The port list SHALL be, clock and reset first:
- CK  input  1  clock; all logic on rising edge.
- SR_N  input  1  synchronous active-low reset, sampled on rising CK.
- REQ  input  N  write request per requester, held until granted.
- CLR  input  N  clear request per requester, held until granted.
- DIN  input  N*W  write data; slice k = DIN[k*W +: W].
- GNT  output  N  one-hot grant, one-cycle pulse.
- CE_O  output  1  write-enable strobe to the shared register.
- SR_O  output  1  clear strobe to the shared register.
- Q  output  W  shared register contents.
- BUSY  output  1  high when state is not IDLE.

Function
REQ-005 The FSM SHALL have the states IDLE, WRITE, CLEAR and COOL.
REQ-006 In IDLE with any CLR bit set, the FSM SHALL enter CLEAR on the next edge.
- CLR takes priority over REQ.
- The winner SHALL be the lowest-index set CLR bit.
REQ-007 In IDLE with no CLR bit set and any REQ bit set, the FSM SHALL enter WRITE on the next edge.
- The winner SHALL be chosen round-robin, starting from pointer P.
REQ-008 In WRITE, the block SHALL:
- assert GNT[k] and CE_O for exactly one cycle;
- load Q with DIN slice k on the edge ending WRITE;
- set P to (k+1) mod N on that edge.
REQ-009 The latency from the REQ sample edge to GNT SHALL be 1 cycle, and the latency to Q update SHALL be 2 cycles.
REQ-010 In CLEAR, the block SHALL assert GNT[k] and SR_O for one cycle, load Q with 0 on the edge ending CLEAR, and leave P unchanged.
REQ-011 After WRITE or CLEAR, the FSM SHALL enter COOL for exactly GAP cycles and then return to IDLE.
- If GAP=0, the FSM SHALL return directly to IDLE.
REQ-012 In COOL, the block SHALL ignore REQ and CLR and SHALL hold GNT, CE_O and SR_O at 0.
REQ-013 The COOL counter SHALL be 4 bits and SHALL NOT wrap; it counts GAP-1 down to 0.
REQ-014 GNT SHALL never have more than one bit set, and CE_O and SR_O SHALL never be high in the same cycle.
REQ-015 Q SHALL change only on an edge ending WRITE or CLEAR, or on reset.
REQ-016 The winner SHALL be latched on IDLE exit.
- Deassertion of REQ or CLR during WRITE, CLEAR or COOL SHALL NOT abort the access.
REQ-017 Requests arriving while BUSY SHALL be served in arbitration order on the next IDLE cycle.
REQ-018 With all N REQ bits held continuously, the grants SHALL rotate 0,1,...,N-1,0 with period N*(GAP+2) cycles.
REQ-019 P SHALL wrap from N-1 to 0.

Reset
REQ-020 When SR_N=0 at a rising CK edge, the block SHALL:
- force the FSM to IDLE;
- set P=0, Q=0 and the COOL counter to 0;
- set GNT=0, CE_O=0, SR_O=0 and BUSY=0.
REQ-021 Reset SHALL take effect in any state, including mid-WRITE. A WRITE aborted by reset SHALL NOT update Q.
REQ-022 The block SHALL hold no asynchronous reset path; outputs SHALL change only on CK edges.
REQ-023 Release of SR_N SHALL be followed by normal arbitration on the first edge at which SR_N=1.

Verification
REQ-024 The bench SHALL cover single write: W=8, reset, REQ=0001 with DIN slice 0=8'hA5 -> GNT=0001 and CE_O=1 one cycle later; Q=8'hA5 two cycles after sampling; BUSY high for 1+GAP cycles.
REQ-025 The bench SHALL cover round-robin: all REQ held with slices k=8'h10+k -> GNT sequence 0001,0010,0100,1000,0001 spaced GAP+2 cycles apart; Q follows 10,11,12,13,10.
REQ-026 The bench SHALL cover clear priority: Q=8'hA5, REQ=0100 and CLR=0010 raised together -> GNT=0010 with SR_O=1, Q=0; next grant GNT=0100 after COOL; P unchanged by the clear.
REQ-027 The bench SHALL cover reset mid-access: SR_N=0 during the WRITE cycle for DIN=8'h3C -> next edge Q=0, IDLE, GNT=0; no later write of 8'h3C unless REQ is still held.
REQ-028 The bench SHALL cover GAP=0: REQ=0011 held -> grants alternate 0001,0010 every 2 cycles; CE_O duty 50%.
REQ-029 The bench SHALL cover the late request: REQ[3] raised during COOL -> no GNT until IDLE; GNT=1000 on the first WRITE after COOL ends.
